// File: rtl/seq_mult_ctrl_taint.sv
// Control FSM for the sequential multiplier. It issues the datapath strobes, supports
// unsigned shift-add or radix-2 Booth, and tracks sticky control-flow taint.
module seq_mult_ctrl_taint #(
    parameter int WIDTH  = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             start_t,
    input  logic [WIDTH-1:0] mr,
    input  logic [WIDTH-1:0] mr_t,
    output logic             busy,
    output logic             busy_t,
    output logic             md_ld,
    output logic             md_ld_t,
    output logic             mr_ld,
    output logic             mr_ld_t,
    output logic             rs_clear,
    output logic             rs_clear_t,
    output logic             rs_load,
    output logic             rs_load_t,
    output logic             rs_sub,
    output logic             rs_sub_t,
    output logic             rs_shr,
    output logic             rs_shr_t,
    output logic             product_done,
    output logic             product_done_t
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        TEST,
        ADD,
        SHIFT,
        DONE
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic          prev;
    logic          op_sub;
    logic          op_sub_n;
    logic          st_t;
    logic          cnt_t;
    logic          prev_t;

    // Next-state and Booth operation selection; b is the multiplier bit under test.
    always_comb begin
        state_n  = state;
        op_sub_n = op_sub;
        case (state)
            IDLE:  if (start) state_n = INIT;
            INIT:  state_n = TEST;
            TEST: begin
                if (SIGNED) begin
                    case ({mr[cnt], prev})
                        2'b10: begin
                            state_n  = ADD;
                            op_sub_n = 1'b1;
                        end
                        2'b01: begin
                            state_n  = ADD;
                            op_sub_n = 1'b0;
                        end
                        default: state_n = SHIFT;
                    endcase
                end else if (mr[cnt]) begin
                    state_n  = ADD;
                    op_sub_n = 1'b0;
                end else begin
                    state_n = SHIFT;
                end
            end
            ADD:   state_n = SHIFT;
            SHIFT: state_n = (cnt == LAST) ? DONE : TEST;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Strobes are registered from the next state, so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            prev         <= 1'b0;
            op_sub       <= 1'b0;
            busy         <= 1'b0;
            md_ld        <= 1'b0;
            mr_ld        <= 1'b0;
            rs_clear     <= 1'b0;
            rs_load      <= 1'b0;
            rs_sub       <= 1'b0;
            rs_shr       <= 1'b0;
            product_done <= 1'b0;
            st_t         <= 1'b0;
            cnt_t        <= 1'b0;
            prev_t       <= 1'b0;
        end else begin
            state        <= state_n;
            op_sub       <= op_sub_n;
            busy         <= (state_n != IDLE);
            md_ld        <= (state_n == INIT);
            mr_ld        <= (state_n == INIT);
            rs_clear     <= (state_n == INIT);
            rs_load      <= (state_n == ADD);
            rs_sub       <= (state_n == ADD) && op_sub_n && SIGNED;
            rs_shr       <= (state_n == SHIFT);
            product_done <= (state_n == DONE);

            if (state == INIT) begin
                cnt  <= '0;
                prev <= 1'b0;
            end else if (state == SHIFT) begin
                prev <= mr[cnt];
                if (cnt != LAST) cnt <= cnt + CW'(1);
            end

            // Taint is sticky: any branch decision that looked at tainted data marks the control path.
            st_t   <= st_t | ((state == IDLE) & start_t)
                           | ((state == TEST) & (mr_t[cnt] | cnt_t | (SIGNED & prev_t)));
            cnt_t  <= cnt_t | st_t;
            prev_t <= prev_t | ((state == SHIFT) & (mr_t[cnt] | cnt_t));
        end
    end

    assign busy_t         = st_t;
    assign md_ld_t        = st_t;
    assign mr_ld_t        = st_t;
    assign rs_clear_t     = st_t;
    assign rs_load_t      = st_t;
    assign rs_sub_t       = st_t;
    assign rs_shr_t       = st_t;
    assign product_done_t = st_t;

endmodule

// File: tb/tb_seq_mult_ctrl_taint.sv
// Directed bench for seq_mult_ctrl_taint: unsigned WIDTH=4, Booth WIDTH=4 and unsigned WIDTH=8
// instances, checking strobe sequences, latency, taint propagation and reset behaviour.
module tb_seq_mult_ctrl_taint;

    logic       clk;
    logic       rst;
    logic [2:0] start_v;
    logic [2:0] start_t_v;
    logic [3:0] mr_a, mr_t_a, mr_b, mr_t_b;
    logic [7:0] mr_c, mr_t_c;

    // Per instance: {busy, md_ld, mr_ld, rs_clear, rs_load, rs_sub, rs_shr, product_done}
    logic [7:0] obs [3];
    logic [7:0] tnt [3];

    int tests_run = 0;
    int failed    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    seq_mult_ctrl_taint #(.WIDTH(4), .SIGNED(1'b0)) dut_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .start_t(start_t_v[0]),
        .mr(mr_a), .mr_t(mr_t_a),
        .busy(obs[0][7]), .busy_t(tnt[0][7]),
        .md_ld(obs[0][6]), .md_ld_t(tnt[0][6]),
        .mr_ld(obs[0][5]), .mr_ld_t(tnt[0][5]),
        .rs_clear(obs[0][4]), .rs_clear_t(tnt[0][4]),
        .rs_load(obs[0][3]), .rs_load_t(tnt[0][3]),
        .rs_sub(obs[0][2]), .rs_sub_t(tnt[0][2]),
        .rs_shr(obs[0][1]), .rs_shr_t(tnt[0][1]),
        .product_done(obs[0][0]), .product_done_t(tnt[0][0])
    );

    seq_mult_ctrl_taint #(.WIDTH(4), .SIGNED(1'b1)) dut_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .start_t(start_t_v[1]),
        .mr(mr_b), .mr_t(mr_t_b),
        .busy(obs[1][7]), .busy_t(tnt[1][7]),
        .md_ld(obs[1][6]), .md_ld_t(tnt[1][6]),
        .mr_ld(obs[1][5]), .mr_ld_t(tnt[1][5]),
        .rs_clear(obs[1][4]), .rs_clear_t(tnt[1][4]),
        .rs_load(obs[1][3]), .rs_load_t(tnt[1][3]),
        .rs_sub(obs[1][2]), .rs_sub_t(tnt[1][2]),
        .rs_shr(obs[1][1]), .rs_shr_t(tnt[1][1]),
        .product_done(obs[1][0]), .product_done_t(tnt[1][0])
    );

    seq_mult_ctrl_taint #(.WIDTH(8), .SIGNED(1'b0)) dut_c (
        .clk(clk), .rst(rst), .start(start_v[2]), .start_t(start_t_v[2]),
        .mr(mr_c), .mr_t(mr_t_c),
        .busy(obs[2][7]), .busy_t(tnt[2][7]),
        .md_ld(obs[2][6]), .md_ld_t(tnt[2][6]),
        .mr_ld(obs[2][5]), .mr_ld_t(tnt[2][5]),
        .rs_clear(obs[2][4]), .rs_clear_t(tnt[2][4]),
        .rs_load(obs[2][3]), .rs_load_t(tnt[2][3]),
        .rs_sub(obs[2][2]), .rs_sub_t(tnt[2][2]),
        .rs_shr(obs[2][1]), .rs_shr_t(tnt[2][1]),
        .product_done(obs[2][0]), .product_done_t(tnt[2][0])
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic setInputs(input int sel, input logic [7:0] m, input logic [7:0] mt);
        case (sel)
            0: begin mr_a = m[3:0]; mr_t_a = mt[3:0]; end
            1: begin mr_b = m[3:0]; mr_t_b = mt[3:0]; end
            default: begin mr_c = m; mr_t_c = mt; end
        endcase
    endtask

    // Runs one multiply from IDLE; cycle 1 is INIT. start is re-driven high only in poke_cyc.
    task automatic applyStimulus(input int sel, input logic [7:0] m, input logic [7:0] mt,
                                 input int poke_cyc, output int done_cyc, output int loads,
                                 output int sub_mask, output int add_mask,
                                 output int first_taint, output int taint_or);
        int cyc;
        int shifts;
        done_cyc    = -1;
        loads       = 0;
        sub_mask    = 0;
        add_mask    = 0;
        first_taint = -1;
        taint_or    = 0;
        shifts      = 0;
        setInputs(sel, m, mt);
        start_v[sel] = 1'b1;
        @(negedge clk);
        cyc = 1;
        for (int i = 0; i < 64; i++) begin
            start_v[sel] = (cyc == poke_cyc);
            if (|tnt[sel]) begin
                taint_or = 1;
                if (first_taint < 0) first_taint = cyc;
            end
            if (obs[sel][3]) begin
                loads++;
                if (obs[sel][2]) sub_mask |= (1 << shifts);
                else             add_mask |= (1 << shifts);
            end
            if (obs[sel][1]) shifts++;
            if (obs[sel][0]) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        checkOutput("done_seen", (done_cyc >= 0) ? 32'd1 : 32'd0, 32'd1);
    endtask

    int dc, ld, sm, am, ft, tor;

    initial begin
        rst       = 1'b1;
        start_v   = '0;
        start_t_v = '0;
        mr_a = '0; mr_t_a = '0; mr_b = '0; mr_t_b = '0; mr_c = '0; mr_t_c = '0;
        doReset();

        // Reset state
        for (int s = 0; s < 3; s++) begin
            checkOutput($sformatf("reset_obs%0d", s), {24'd0, obs[s]}, 32'd0);
            checkOutput($sformatf("reset_tnt%0d", s), {24'd0, tnt[s]}, 32'd0);
        end

        // T1: unsigned mr=0 -> no ADD, done at 10, no taint
        applyStimulus(0, 8'h00, 8'h00, -1, dc, ld, sm, am, ft, tor);
        checkOutput("t1_done", dc, 10);
        checkOutput("t1_loads", ld, 0);
        checkOutput("t1_taint", tor, 0);
        @(negedge clk);

        // T2: unsigned mr=F -> four adds, done at 14
        applyStimulus(0, 8'h0F, 8'h00, -1, dc, ld, sm, am, ft, tor);
        checkOutput("t2_done", dc, 14);
        checkOutput("t2_loads", ld, 4);
        checkOutput("t2_add_mask", am, 32'hF);
        checkOutput("t2_sub_mask", sm, 0);
        @(negedge clk);

        // T3: Booth mr=0110 -> sub at bit1, add at bit3, done at 12
        applyStimulus(1, 8'h06, 8'h00, -1, dc, ld, sm, am, ft, tor);
        checkOutput("t3_done", dc, 12);
        checkOutput("t3_loads", ld, 2);
        checkOutput("t3_sub_mask", sm, 32'b0010);
        checkOutput("t3_add_mask", am, 32'b1000);
        @(negedge clk);

        // Booth mr=1111 -> single sub at bit0, done at 11
        applyStimulus(1, 8'h0F, 8'h00, -1, dc, ld, sm, am, ft, tor);
        checkOutput("booth_f_done", dc, 11);
        checkOutput("booth_f_sub_mask", sm, 32'b0001);
        checkOutput("booth_f_add_mask", am, 0);
        @(negedge clk);

        // T4: taint on mr bit2 appears the cycle after that bit's TEST (cycle 7)
        doReset();
        applyStimulus(0, 8'h00, 8'h04, -1, dc, ld, sm, am, ft, tor);
        checkOutput("t4_first_taint", ft, 7);
        checkOutput("t4_done", dc, 10);
        @(negedge clk);
        checkOutput("t4_idle_busy", obs[0][7], 1'b0);
        checkOutput("t4_idle_tnt", {24'd0, tnt[0]}, 32'hFF);
        doReset();
        checkOutput("t4_rst_tnt", {24'd0, tnt[0]}, 32'd0);

        // T5: tainted start with start low taints the control path but stays idle
        start_t_v[0] = 1'b1;
        @(negedge clk);
        start_t_v[0] = 1'b0;
        checkOutput("t5_busy_t", tnt[0][7], 1'b1);
        checkOutput("t5_busy", obs[0][7], 1'b0);
        @(negedge clk);
        checkOutput("t5_still_idle", obs[0], 8'h00);
        doReset();

        // T6a: reset while in ADD -> everything clears, no done pulse afterwards
        setInputs(0, 8'h0F, 8'h00);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        dc = 0;
        for (int i = 0; i < 8 && !obs[0][3]; i++) begin
            @(negedge clk);
            dc++;
        end
        checkOutput("t6_add_reached", obs[0][3], 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("t6_rst_obs", {24'd0, obs[0]}, 32'd0);
        checkOutput("t6_rst_tnt", {24'd0, tnt[0]}, 32'd0);
        @(negedge clk);
        checkOutput("t6_no_done", {24'd0, obs[0]}, 32'd0);

        // T6b: start pulsed while busy is neither honoured nor queued
        applyStimulus(0, 8'h00, 8'h00, 4, dc, ld, sm, am, ft, tor);
        checkOutput("t6_ign_done", dc, 10);
        @(negedge clk);
        checkOutput("t6_ign_idle1", obs[0][7], 1'b0);
        @(negedge clk);
        checkOutput("t6_ign_idle2", obs[0][7], 1'b0);

        // Back-to-back: start high during DONE -> IDLE, then INIT
        applyStimulus(0, 8'h00, 8'h00, 10, dc, ld, sm, am, ft, tor);
        checkOutput("b2b_done", dc, 10);
        @(negedge clk);
        checkOutput("b2b_idle", obs[0][7], 1'b0);
        @(negedge clk);
        start_v[0] = 1'b0;
        checkOutput("b2b_init", obs[0], 8'hF0);
        doReset();

        // T6c: WIDTH=8 unsigned, add count equals popcount, done at 18 + k
        begin
            logic [7:0] vec [4];
            vec[0] = 8'h00;
            vec[1] = 8'hA5;
            vec[2] = 8'hFF;
            vec[3] = 8'($urandom);
            for (int v = 0; v < 4; v++) begin
                applyStimulus(2, vec[v], 8'h00, -1, dc, ld, sm, am, ft, tor);
                checkOutput($sformatf("w8_loads_%02h", vec[v]), ld, $countones(vec[v]));
                checkOutput($sformatf("w8_done_%02h", vec[v]), dc, 18 + $countones(vec[v]));
                checkOutput($sformatf("w8_mask_%02h", vec[v]), am, {24'd0, vec[v]});
                checkOutput($sformatf("w8_taint_%02h", vec[v]), tor, 0);
                @(negedge clk);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
